phys_free_list: RTL and testbench

- Circular FIFO of free physical register indices.
- Sits between the commit-side RRF and the dispatch-side RAT:
  - accepts up to SS freed registers per cycle from the RRF (free_list_push / old_phys_reg);
  - supplies up to SS fresh destination registers per cycle to rename/dispatch, which drive pd_dispatch into the RAT.
- On a branch mispredict it rewinds so that every register not mapped in the RRF is free again.

---
 rtl/phys_free_list.sv | 89 ++++++++
 tb/tb_phys_free_list.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/phys_free_list.sv
// Circular FIFO of free physical register indices between the RRF (frees) and rename (allocates).
// A mispredict rewinds head onto tail so every entry behind tail becomes free again.
module phys_free_list #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int WIDTH         = 6,
  parameter int SS            = 2,
  parameter int SS_BITS       = 1,
  parameter int DEPTH         = NUM_PHYS_REGS - 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               mispredict,
  input  logic [SS_BITS:0]                   pop_cnt,
  output logic [SS-1:0][WIDTH-1:0]           pd_dispatch,
  output logic [$clog2(DEPTH+1)-1:0]         free_cnt,
  input  logic [SS_BITS:0]                   push_cnt,
  input  logic [SS-1:0][WIDTH-1:0]           push_regs,
  output logic                               err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] queue_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic             pop_ok, push_ok, zero_seen;
  logic [CNT_W:0]   pop_ext, push_ext, cnt_ext, pops, occ_after;

  // DEPTH need not be a power of two, so wrap by compare rather than truncation.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int unsigned n);
    int unsigned s;
    s = 32'(p) + n;
    if (s >= 32'(DEPTH)) s = s - 32'(DEPTH);
    return PTR_W'(s);
  endfunction

  always_comb begin
    pop_ext   = (CNT_W+1)'(pop_cnt);
    push_ext  = (CNT_W+1)'(push_cnt);
    cnt_ext   = (CNT_W+1)'(count_q);
    pop_ok    = mispredict || (pop_ext <= cnt_ext);
    pops      = (mispredict || !pop_ok) ? '0 : pop_ext;
    occ_after = cnt_ext - pops + push_ext;
    push_ok   = occ_after <= (CNT_W+1)'(DEPTH);

    zero_seen = 1'b0;
    for (int unsigned i = 0; i < SS; i++) begin
      if (i < 32'(push_cnt) && push_regs[i] == '0) zero_seen = 1'b1;
    end

    tail_d  = push_ok ? wrap_add(tail_q, 32'(push_cnt)) : tail_q;
    head_d  = mispredict ? tail_d : wrap_add(head_q, 32'(pops));
    count_d = mispredict ? CNT_W'(DEPTH)
                         : (push_ok ? CNT_W'(occ_after) : CNT_W'(cnt_ext - pops));
    err_d   = err_q | ~pop_ok | ~push_ok | zero_seen;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) queue_q[i] <= WIDTH'(32 + i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CNT_W'(DEPTH);
      err_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < SS; i++) begin
        if (push_ok && i < 32'(push_cnt)) queue_q[wrap_add(tail_q, i)] <= push_regs[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < SS; i++) begin
      pd_dispatch[i] = (i < 32'(count_q)) ? queue_q[wrap_add(head_q, i)] : '0;
    end
  end

  assign free_cnt = count_q;
  assign err      = err_q;

endmodule

// File: tb/tb_phys_free_list.sv
// Bench for phys_free_list: directed scenarios then random traffic against a ring-buffer reference.
module tb_phys_free_list;

  localparam int DEPTH = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            mispredict = 1'b0;
  logic [1:0]      pop_cnt = '0;
  logic [1:0]      push_cnt = '0;
  logic [1:0][5:0] push_regs = '0;
  logic [1:0][5:0] pd_dispatch;
  logic [5:0]      free_cnt;
  logic            err;

  int checks = 0;
  int failures = 0;

  int m_q [DEPTH];
  int m_head, m_tail, m_cnt;
  bit m_err;

  phys_free_list #(
    .NUM_PHYS_REGS(64),
    .WIDTH(6),
    .SS(2),
    .SS_BITS(1),
    .DEPTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mispredict(mispredict),
    .pop_cnt(pop_cnt),
    .pd_dispatch(pd_dispatch),
    .free_cnt(free_cnt),
    .push_cnt(push_cnt),
    .push_regs(push_regs),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_q[i] = 32 + i;
    m_head = 0; m_tail = 0; m_cnt = DEPTH; m_err = 1'b0;
  endfunction

  function automatic void model_step(input bit mp, input int pc, input int qc, input int r0, input int r1);
    int pops = 0;
    int regs [2];
    regs[0] = r0; regs[1] = r1;
    if (!mp) begin
      if (pc <= m_cnt) pops = pc;
      else m_err = 1'b1;
    end
    m_cnt  = m_cnt - pops;
    m_head = (m_head + pops) % DEPTH;
    if (m_cnt + qc > DEPTH) m_err = 1'b1;
    else begin
      for (int i = 0; i < qc; i++) begin
        m_q[(m_tail + i) % DEPTH] = regs[i];
        if (regs[i] == 0) m_err = 1'b1;
      end
      m_tail = (m_tail + qc) % DEPTH;
      m_cnt  = m_cnt + qc;
    end
    if (mp) begin
      m_head = m_tail;
      m_cnt  = DEPTH;
    end
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".free_cnt"}, int'(free_cnt), m_cnt);
    chk({tag, ".err"}, int'(err), int'(m_err));
    for (int i = 0; i < 2; i++)
      chk($sformatf("%s.pd%0d", tag, i), int'(pd_dispatch[i]),
          (i < m_cnt) ? m_q[(m_head + i) % DEPTH] : 0);
  endtask

  // Drive one cycle of inputs from the falling edge, let the rising edge take them, check on the next falling edge.
  task automatic cycle(input string tag, input bit mp, input int pc, input int qc, input int r0, input int r1);
    mispredict = mp;
    pop_cnt = 2'(pc);
    push_cnt = 2'(qc);
    push_regs[0] = 6'(r0);
    push_regs[1] = 6'(r1);
    @(posedge clk);
    model_step(mp, pc, qc, r0, r1);
    @(negedge clk);
    mispredict = 1'b0; pop_cnt = '0; push_cnt = '0; push_regs = '0;
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst.async_free_cnt", int'(free_cnt), DEPTH);
    chk("rst.async_err", int'(err), 0);
    @(negedge clk);
    rst = 1'b0;
    check_model("rst");
  endtask

  initial begin
    do_reset();
    chk("reset.pd0", int'(pd_dispatch[0]), 32);
    chk("reset.pd1", int'(pd_dispatch[1]), 33);

    cycle("pop2", 1'b0, 2, 0, 0, 0);
    chk("pop2.free", int'(free_cnt), 30);
    chk("pop2.pd0", int'(pd_dispatch[0]), 34);
    chk("pop2.pd1", int'(pd_dispatch[1]), 35);

    for (int i = 0; i < 15; i++) cycle("drain", 1'b0, 2, 0, 0, 0);
    chk("empty.free", int'(free_cnt), 0);
    chk("empty.pd0", int'(pd_dispatch[0]), 0);
    cycle("underflow", 1'b0, 1, 0, 0, 0);
    chk("underflow.free", int'(free_cnt), 0);
    chk("underflow.err", int'(err), 1);

    cycle("push59", 1'b0, 0, 2, 5, 9);
    chk("push59.free", int'(free_cnt), 2);
    chk("push59.pd0", int'(pd_dispatch[0]), 5);
    chk("push59.pd1", int'(pd_dispatch[1]), 9);
    cycle("pop1", 1'b0, 1, 0, 0, 0);
    cycle("pushpop", 1'b0, 1, 1, 7, 0);
    chk("pushpop.free", int'(free_cnt), 1);
    chk("pushpop.pd0", int'(pd_dispatch[0]), 7);

    do_reset();
    for (int i = 0; i < 15; i++) cycle("wrap.pop", 1'b0, 2, 0, 0, 0);
    cycle("wrap.pop1", 1'b0, 1, 0, 0, 0);
    chk("wrap.head63", int'(pd_dispatch[0]), 63);
    cycle("wrap.push2", 1'b0, 0, 2, 40, 41);
    cycle("wrap.push1", 1'b0, 0, 1, 42, 0);
    chk("wrap.free4", int'(free_cnt), 4);
    cycle("wrap.popA", 1'b0, 1, 0, 0, 0);
    chk("wrap.seq40", int'(pd_dispatch[0]), 40);
    cycle("wrap.popB", 1'b0, 1, 0, 0, 0);
    chk("wrap.seq41", int'(pd_dispatch[0]), 41);
    cycle("wrap.popC", 1'b0, 1, 0, 0, 0);
    chk("wrap.seq42", int'(pd_dispatch[0]), 42);
    chk("wrap.err", int'(err), 0);

    do_reset();
    for (int i = 0; i < 5; i++) cycle("mp.pop", 1'b0, 2, 0, 0, 0);
    chk("mp.free22", int'(free_cnt), 22);
    cycle("mp.flush", 1'b1, 2, 2, 36, 37);
    chk("mp.free", int'(free_cnt), 32);
    chk("mp.pd0", int'(pd_dispatch[0]), 34);
    chk("mp.pd1", int'(pd_dispatch[1]), 35);
    chk("mp.err", int'(err), 0);

    do_reset();
    cycle("ovf", 1'b0, 0, 1, 20, 0);
    chk("ovf.free", int'(free_cnt), 32);
    chk("ovf.pd0", int'(pd_dispatch[0]), 32);
    chk("ovf.err", int'(err), 1);
    do_reset();

    for (int n = 0; n < 600; n++) begin
      int r0, r1;
      if (n % 80 == 79) do_reset();
      r0 = ($urandom_range(0, 31) == 0) ? 0 : int'($urandom_range(1, 63));
      r1 = int'($urandom_range(1, 63));
      cycle("rand", ($urandom_range(0, 15) == 0), int'($urandom_range(0, 2)),
            int'($urandom_range(0, 2)), r0, r1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
